multicycle_stage_sequencer: RTL and testbench
=============================================

Name: multicycle_stage_sequencer

Overview:
- Stage sequencer FSM for the multi-cycle RV32I core.
- Generates the {inst, stage} index that addresses the microcode control ROM, which is indexed as {inst[4:0], stage[2:0]}.
- Walks each instruction through only the stages its class needs, and holds the current stage on memory wait states.
- Enters a terminal halt state on the halt class or an illegal class, and keeps cycle and retired-instruction counters.

Parameters:
CNT_W, 32, width of cycle_cnt and retire_cnt
HALT_CLASS, 28, instruction class that halts the core

Ports:
CLK  input  1  clock; all state updates on rising edge
RSTn  input  1  reset, synchronous, active-low
inst_class  input  5  class decoded from instruction-memory read data; valid during IF
imem_ready  input  1  instruction fetch data valid
dmem_ready  input  1  data memory access complete
inst_out  output  5  ROM index high bits
stage  output  3  ROM index low bits: IF=0, ID=1, EX=2, MEM=3, WB=4
stall  output  1  top level gates PC/IR/RF/ALU-reg/DMEM write enables while high
retire  output  1  final-stage cycle of an instruction that advances this cycle
halted  output  1  core halted
illegal  output  1  halt was caused by class 29..31
cycle_cnt  output  CNT_W  non-halted cycles
retire_cnt  output  CNT_W  retired instructions

Behaviour:
- Clock and reset: one clock (CLK). Reset is synchronous, active-low on RSTn. While RSTn=0 at an edge: stage=IF, class_q=0, halted=0, illegal=0, cycle_cnt=0, retire_cnt=0. Reset takes priority over any in-flight instruction; no partial state survives.
- inst_out mux:
  - In IF: inst_out = inst_class (combinational pass-through).
  - In ID/EX/MEM/WB: inst_out = class_q, latched at the edge leaving IF.
  - When halted: inst_out = HALT_CLASS and stage = 0.
- Stage register never holds encodings 5..7.
- Class groups:
  - R/I = 0..19
  - LW = 20, SW = 21, JALR = 22, JAL = 23
  - BR = 24..25, LUI = 26, AUIPC = 27
- IF, when imem_ready=1, transitions on inst_class:
  - R/I/LW/SW/JALR/BR → ID
  - JAL/AUIPC → EX
  - LUI → WB
  - HALT_CLASS → halted=1
  - 29..31 → halted=1 and illegal=1
- IF, when imem_ready=0: stay in IF, do not latch the class, stall=1.
- ID → EX, unconditional.
- EX:
  - LW/SW → MEM
  - BR → IF, retire=1
  - all others → WB
- MEM:
  - dmem_ready=0: hold MEM, stall=1.
  - dmem_ready=1, LW → WB.
  - dmem_ready=1, SW → IF, retire=1.
- WB → IF, retire=1.
- Resulting stage counts: R/I/JALR 4; LW 5; SW 4; BR 3; JAL/AUIPC 3; LUI 2 (excluding stall cycles).
- Halted state:
  - Terminal until reset.
  - stall=1, retire=0, counters frozen.
  - The halt instruction itself does not retire.
- retire: combinational, high only in the advancing final-stage cycle, never during stall.
- cycle_cnt: +1 every edge while not halted, including stall cycles and the IF cycle that detects halt.
- retire_cnt: +1 on edges where retire=1.
- Both counters wrap modulo 2^CNT_W with no saturation or flag.
- stall: (stage==IF & !imem_ready) | (stage==MEM & !dmem_ready) | halted.

Test Plan:
1. Reset, then ADD (class 0) with both ready=1 → stage 0,1,2,4,0 on successive cycles; inst_out 0 throughout; retire high in the WB cycle only; retire_cnt=1, cycle_cnt=4.
2. LW (20) with dmem_ready low for 3 MEM cycles → stage 0,1,2,3,3,3,3,4,0; stall high exactly the 3 wait cycles; retire_cnt=1, cycle_cnt=8.
3. Sequence LUI(26), JAL(23), BEQ(24), SW(21), all ready → stages 0,4 | 0,2,4 | 0,1,2 | 0,1,2,3 | 0; retire_cnt=4 after 12 cycles.
4. Class 28 in IF → next cycle halted=1, illegal=0, stall=1, inst_out=28, stage=0; counters unchanged over 10 further cycles. Repeat with class 30 → illegal=1.
5. RSTn low during the MEM stall of an SW → next edge stage=0, halted=0, counters 0; a following ADD completes normally.
6. CNT_W=4 build, 16 branch instructions (class 25) → retire_cnt wraps 15→0; cycle_cnt wraps after 16 cycles.

Source files
------------

// File: rtl/multicycle_stage_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_stage_sequencer
//
// Stage sequencer for the multi-cycle RV32I core. It produces the
// {inst, stage} index for the microcode control ROM ({inst[4:0], stage[2:0]}).
// Each instruction visits only the stages its class needs. Memory wait states
// hold the current stage. The halt class and the illegal classes (29..31) put
// the core into a halt state that only reset clears. The block also counts
// non-halted cycles and retired instructions.
//
// Ports
//   CLK         clock; all state updates on the rising edge
//   RSTn        synchronous active-low reset
//   inst_class  class decoded from instruction-memory data, valid during IF
//   imem_ready  instruction fetch data valid
//   dmem_ready  data memory access complete
//   inst_out    ROM index high bits (class)
//   stage       ROM index low bits: IF=0, ID=1, EX=2, MEM=3, WB=4
//   stall       freeze PC/IR/RF/ALU-reg/DMEM write enables
//   retire      last-stage cycle of an instruction that advances this cycle
//   halted      core halted (terminal until reset)
//   illegal     halt was caused by class 29..31
//   cycle_cnt   non-halted cycle counter (wraps)
//   retire_cnt  retired instruction counter (wraps)
// -----------------------------------------------------------------------------
module multicycle_stage_sequencer #(
  parameter int CNT_W      = 32,
  parameter int HALT_CLASS = 28
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [4:0]       inst_class,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic [4:0]       inst_out,
  output logic [2:0]       stage,
  output logic             stall,
  output logic             retire,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } stage_e;

  localparam logic [4:0] HALT_C      = 5'(HALT_CLASS);
  localparam logic [4:0] CLS_LW      = 5'd20;
  localparam logic [4:0] CLS_SW      = 5'd21;
  localparam logic [4:0] CLS_JAL     = 5'd23;
  localparam logic [4:0] CLS_BR_LO   = 5'd24;
  localparam logic [4:0] CLS_BR_HI   = 5'd25;
  localparam logic [4:0] CLS_LUI     = 5'd26;
  localparam logic [4:0] CLS_AUIPC   = 5'd27;
  localparam logic [4:0] CLS_ILL_MIN = 5'd29;

  stage_e     stage_q;
  logic [4:0] class_q;

  // First stage after IF depends only on the fetched class.
  function automatic stage_e first_stage(input logic [4:0] c);
    if (c == CLS_JAL || c == CLS_AUIPC) return ST_EX;
    else if (c == CLS_LUI)              return ST_WB;
    else                                return ST_ID;
  endfunction

  function automatic logic is_branch(input logic [4:0] c);
    return (c == CLS_BR_LO) || (c == CLS_BR_HI);
  endfunction

  function automatic logic is_mem(input logic [4:0] c);
    return (c == CLS_LW) || (c == CLS_SW);
  endfunction

  // Outputs derived from state plus the current ready/class inputs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    inst_out = class_q;
    stage    = stage_q;
    stall    = 1'b0;
    retire   = 1'b0;
    if (halted) begin
      inst_out = HALT_C;
      stage    = ST_IF;
      stall    = 1'b1;
    end else begin
      unique case (stage_q)
        ST_IF: begin
          inst_out = inst_class;
          stall    = !imem_ready;
        end
        ST_EX:  retire = is_branch(class_q);
        ST_MEM: begin
          stall  = !dmem_ready;
          retire = dmem_ready && (class_q == CLS_SW);
        end
        ST_WB:  retire = 1'b1;
        default: ;
      endcase
    end
  end

  // Stage walk, class latch, halt flags and counters.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!RSTn) begin
      stage_q    <= ST_IF;
      class_q    <= '0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else if (!halted) begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (retire) retire_cnt <= retire_cnt + 1'b1;

      unique case (stage_q)
        ST_IF: begin
          if (imem_ready) begin
            if (inst_class == HALT_C) begin
              halted <= 1'b1;
            end else if (inst_class >= CLS_ILL_MIN) begin
              halted  <= 1'b1;
              illegal <= 1'b1;
            end else begin
              class_q <= inst_class;
              stage_q <= first_stage(inst_class);
            end
          end
        end
        ST_ID: stage_q <= ST_EX;
        ST_EX: begin
          if (is_mem(class_q))        stage_q <= ST_MEM;
          else if (is_branch(class_q)) stage_q <= ST_IF;
          else                         stage_q <= ST_WB;
        end
        ST_MEM: begin
          if (dmem_ready) stage_q <= (class_q == CLS_LW) ? ST_WB : ST_IF;
        end
        ST_WB:   stage_q <= ST_IF;
        // Encodings 5..7 are unreachable; recover to IF if ever seen.
        default: stage_q <= ST_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_stage_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for multicycle_stage_sequencer.
// A 32-bit-counter instance and a 4-bit-counter instance share all inputs.
// Directed table vectors, hand sequences for halt/reset/wrap, then random
// stimulus against a path-list reference model.
// -----------------------------------------------------------------------------
module tb_multicycle_stage_sequencer;

  logic        CLK;
  logic        RSTn;
  logic [4:0]  inst_class;
  logic        imem_ready;
  logic        dmem_ready;

  logic [4:0]  inst_out,   inst_out4;
  logic [2:0]  stage,      stage4;
  logic        stall,      stall4;
  logic        retire,     retire4;
  logic        halted,     halted4;
  logic        illegal,    illegal4;
  logic [31:0] cycle_cnt,  retire_cnt;
  logic [3:0]  cycle_cnt4, retire_cnt4;

  multicycle_stage_sequencer #(.CNT_W(32), .HALT_CLASS(28)) dut (
    .CLK(CLK), .RSTn(RSTn), .inst_class(inst_class),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .inst_out(inst_out), .stage(stage), .stall(stall), .retire(retire),
    .halted(halted), .illegal(illegal),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  multicycle_stage_sequencer #(.CNT_W(4), .HALT_CLASS(28)) dut4 (
    .CLK(CLK), .RSTn(RSTn), .inst_class(inst_class),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .inst_out(inst_out4), .stage(stage4), .stall(stall4), .retire(retire4),
    .halted(halted4), .illegal(illegal4),
    .cycle_cnt(cycle_cnt4), .retire_cnt(retire_cnt4)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- reference model ----------------
  // An instruction is the list of stages it visits; pos indexes into it.
  bit m_halt, m_ill;
  int m_cls;
  int path[$];
  int pos;
  int m_cyc, m_ret;

  function void build_path(input int c);
    if (c == 20)                 path = '{0, 1, 2, 3, 4};
    else if (c == 21)            path = '{0, 1, 2, 3};
    else if (c == 24 || c == 25) path = '{0, 1, 2};
    else if (c == 23 || c == 27) path = '{0, 2, 4};
    else if (c == 26)            path = '{0, 4};
    else                         path = '{0, 1, 2, 4};
  endfunction

  function int exp_stage();
    if (m_halt || pos == 0) return 0;
    return path[pos];
  endfunction

  function int exp_inst();
    if (m_halt)   return 28;
    if (pos == 0) return int'(inst_class);
    return m_cls;
  endfunction

  function int exp_stall();
    if (m_halt)   return 1;
    if (pos == 0) return imem_ready ? 0 : 1;
    return (path[pos] == 3 && !dmem_ready) ? 1 : 0;
  endfunction

  function int exp_retire();
    if (m_halt || pos == 0) return 0;
    return (exp_stall() == 0 && pos == path.size() - 1) ? 1 : 0;
  endfunction

  always @(posedge CLK) begin
    int r, s;
    r = exp_retire();
    s = exp_stall();
    if (!RSTn) begin
      m_halt = 0; m_ill = 0; m_cls = 0; pos = 0; m_cyc = 0; m_ret = 0;
    end else if (!m_halt) begin
      m_cyc++;
      if (pos == 0) begin
        if (imem_ready) begin
          if (inst_class == 5'd28) m_halt = 1;
          else if (inst_class >= 5'd29) begin m_halt = 1; m_ill = 1; end
          else begin
            build_path(int'(inst_class));
            m_cls = int'(inst_class);
            pos = 1;
          end
        end
      end else if (s == 0) begin
        if (r != 0) begin m_ret++; pos = 0; end
        else pos++;
      end
    end
  end

  task automatic check_model();
    check("m_stage",   int'(stage),      exp_stage());
    check("m_inst",    int'(inst_out),   exp_inst());
    check("m_stall",   int'(stall),      exp_stall());
    check("m_retire",  int'(retire),     exp_retire());
    check("m_halted",  int'(halted),     int'(m_halt));
    check("m_illegal", int'(illegal),    int'(m_ill));
    check("m_cyc",     int'(cycle_cnt),  m_cyc);
    check("m_ret",     int'(retire_cnt), m_ret);
    check("m_cyc4",    int'(cycle_cnt4), m_cyc & 15);
    check("m_ret4",    int'(retire_cnt4), m_ret & 15);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int cls; bit im; bit dm;
    int st; int io; bit sl; bit rt; int cy; int rc;
  } vec_t;

  vec_t vecs[$];

  function void add(input int cls, input bit im, input bit dm, input int st,
                    input int io, input bit sl, input bit rt, input int cy, input int rc);
    vec_t v;
    v.cls = cls; v.im = im; v.dm = dm; v.st = st; v.io = io;
    v.sl = sl; v.rt = rt; v.cy = cy; v.rc = rc;
    vecs.push_back(v);
  endfunction

  task automatic do_reset();
    RSTn = 1'b0; inst_class = '0; imem_ready = 1'b1; dmem_ready = 1'b1;
    tick();
    tick();
    RSTn = 1'b1;
  endtask

  initial begin
    RSTn = 1'b0; inst_class = '0; imem_ready = 1'b0; dmem_ready = 1'b0;

    //  cls im dm  st io sl rt  cy rc
    add( 0, 1, 1,  0, 0, 0, 0,  0, 0);   // ADD: IF
    add(31, 0, 1,  1, 0, 0, 0,  1, 0);   // ID ignores class/imem_ready
    add( 9, 1, 0,  2, 0, 0, 0,  2, 0);   // EX ignores dmem_ready
    add( 5, 1, 1,  4, 0, 0, 1,  3, 0);   // WB retires
    add(20, 1, 1,  0,20, 0, 0,  4, 1);   // LW: IF
    add( 3, 1, 1,  1,20, 0, 0,  5, 1);
    add( 3, 1, 1,  2,20, 0, 0,  6, 1);
    add( 3, 1, 0,  3,20, 1, 0,  7, 1);   // three MEM wait cycles
    add( 3, 1, 0,  3,20, 1, 0,  8, 1);
    add( 3, 1, 0,  3,20, 1, 0,  9, 1);
    add( 3, 1, 1,  3,20, 0, 0, 10, 1);   // LW MEM complete, no retire
    add( 3, 1, 1,  4,20, 0, 1, 11, 1);
    add(26, 1, 1,  0,26, 0, 0, 12, 2);   // LUI
    add( 0, 1, 1,  4,26, 0, 1, 13, 2);
    add(23, 1, 1,  0,23, 0, 0, 14, 3);   // JAL
    add( 0, 1, 1,  2,23, 0, 0, 15, 3);
    add( 0, 1, 1,  4,23, 0, 1, 16, 3);
    add(24, 1, 1,  0,24, 0, 0, 17, 4);   // BEQ
    add( 0, 1, 1,  1,24, 0, 0, 18, 4);
    add( 0, 1, 1,  2,24, 0, 1, 19, 4);   // branch retires from EX
    add(21, 1, 1,  0,21, 0, 0, 20, 5);   // SW
    add( 0, 1, 1,  1,21, 0, 0, 21, 5);
    add( 0, 1, 1,  2,21, 0, 0, 22, 5);
    add( 0, 1, 1,  3,21, 0, 1, 23, 5);   // SW retires from MEM
    add(28, 0, 1,  0,28, 1, 0, 24, 6);   // halt class ignored while imem not ready
    add(30, 0, 1,  0,30, 1, 0, 25, 6);

    do_reset();
    check("rst_stage",  int'(stage), 0);
    check("rst_halted", int'(halted), 0);
    check("rst_cyc",    int'(cycle_cnt), 0);
    check("rst_ret",    int'(retire_cnt), 0);

    foreach (vecs[i]) begin
      inst_class = 5'(vecs[i].cls);
      imem_ready = vecs[i].im;
      dmem_ready = vecs[i].dm;
      #1;
      check($sformatf("v%0d_stage", i),  int'(stage),      vecs[i].st);
      check($sformatf("v%0d_inst", i),   int'(inst_out),   vecs[i].io);
      check($sformatf("v%0d_stall", i),  int'(stall),      int'(vecs[i].sl));
      check($sformatf("v%0d_retire", i), int'(retire),     int'(vecs[i].rt));
      check($sformatf("v%0d_halted", i), int'(halted),     0);
      check($sformatf("v%0d_cyc", i),    int'(cycle_cnt),  vecs[i].cy);
      check($sformatf("v%0d_ret", i),    int'(retire_cnt), vecs[i].rc);
      tick();
    end

    // ---- halt class 28 from IF ----
    inst_class = 5'd28; imem_ready = 1'b1;
    #1;
    check("h_pre_stall", int'(stall), 0);
    tick();
    check("h_halted",  int'(halted), 1);
    check("h_illegal", int'(illegal), 0);
    check("h_stall",   int'(stall), 1);
    check("h_inst",    int'(inst_out), 28);
    check("h_stage",   int'(stage), 0);
    check("h_cyc",     int'(cycle_cnt), 27);
    check("h_ret",     int'(retire_cnt), 6);
    for (int k = 0; k < 10; k++) begin
      inst_class = 5'($urandom_range(0, 31));
      imem_ready = 1'($urandom_range(0, 1));
      dmem_ready = 1'($urandom_range(0, 1));
      tick();
      check("h_hold_halted", int'(halted), 1);
      check("h_hold_retire", int'(retire), 0);
    end
    check("h_frozen_cyc", int'(cycle_cnt), 27);
    check("h_frozen_ret", int'(retire_cnt), 6);

    // ---- illegal class 30 ----
    do_reset();
    inst_class = 5'd30; imem_ready = 1'b1;
    tick();
    check("i_halted",  int'(halted), 1);
    check("i_illegal", int'(illegal), 1);
    check("i_inst",    int'(inst_out), 28);
    check("i_cyc",     int'(cycle_cnt), 1);
    check("i_ret",     int'(retire_cnt), 0);

    // ---- reset during SW MEM stall, then ADD ----
    do_reset();
    inst_class = 5'd21; imem_ready = 1'b1; dmem_ready = 1'b0;
    tick(); tick(); tick();
    check("r_mem_stage", int'(stage), 3);
    check("r_mem_stall", int'(stall), 1);
    tick();
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
    check("r_stage",  int'(stage), 0);
    check("r_halted", int'(halted), 0);
    check("r_cyc",    int'(cycle_cnt), 0);
    check("r_ret",    int'(retire_cnt), 0);
    inst_class = 5'd0; dmem_ready = 1'b1;
    #1;
    check("r_add_if", int'(stage), 0);
    tick();
    check("r_add_id", int'(stage), 1);
    check("r_add_inst", int'(inst_out), 0);
    tick();
    check("r_add_ex", int'(stage), 2);
    tick();
    check("r_add_wb", int'(stage), 4);
    check("r_add_retire", int'(retire), 1);
    tick();
    check("r_add_done", int'(stage), 0);
    check("r_add_cyc", int'(cycle_cnt), 4);
    check("r_add_ret", int'(retire_cnt), 1);

    // ---- 4-bit counter wrap with branches ----
    do_reset();
    inst_class = 5'd25; imem_ready = 1'b1; dmem_ready = 1'b1;
    for (int k = 0; k < 16; k++) tick();
    check("w_cyc4_16", int'(cycle_cnt4), 0);
    check("w_ret4_16", int'(retire_cnt4), 5);
    for (int k = 0; k < 29; k++) tick();
    check("w_ret4_15", int'(retire_cnt4), 15);
    check("w_cyc4_45", int'(cycle_cnt4), 13);
    for (int k = 0; k < 3; k++) tick();
    check("w_ret4_wrap", int'(retire_cnt4), 0);
    check("w_cyc4_48",   int'(cycle_cnt4), 0);
    check("w_ret32",     int'(retire_cnt), 16);
    check("w_cyc32",     int'(cycle_cnt), 48);

    // ---- random stimulus against the model ----
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 63) == 0) inst_class = 5'($urandom_range(28, 31));
      else                            inst_class = 5'($urandom_range(0, 27));
      imem_ready = ($urandom_range(0, 3) != 0);
      dmem_ready = ($urandom_range(0, 3) != 0);
      RSTn = !((m_halt && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0);
      #1;
      check_model();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
